// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port 32-bit data memory, byte/half/word loads and stores; DATA_MEM_MISALIGN_TRAP_EN traps misaligned half/word.
// Latency: response valid in the cycle after acceptance edge + WAIT_STATES + 1.
// Backpressure: one request in flight; req_ready only when idle, response held until resp_ready.
module data_mem_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);
    localparam int         IDX_W   = ADDR_W - 2;
    localparam int         DEPTH   = 2 ** IDX_W;
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              uns;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    state_t             state, state_nxt;
    logic [3:0]         wait_cnt, wait_cnt_nxt;
    req_t               req_q;
    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic [1:0]         lane;
    logic               misalign;
    logic               access_err;
    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        load_data;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;
    logic               mem_we;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    wait_cnt_nxt = WS_INIT;
                    state_nxt    = (WS_INIT == 4'd0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= '{we: req_we, size: req_size, uns: req_unsigned,
                       addr: req_addr, wdata: req_wdata};
        end
    end

    // Without the trap build, misaligned low bits are simply dropped here.
    always_comb begin
        lane     = 2'b00;
        misalign = 1'b0;
        case (req_q.size)
            SZ_BYTE: lane = req_q.addr[1:0];
            SZ_HALF: begin
                lane = {req_q.addr[1], 1'b0};
`ifdef DATA_MEM_MISALIGN_TRAP_EN
                misalign = req_q.addr[0];
`endif
            end
            SZ_WORD: begin
`ifdef DATA_MEM_MISALIGN_TRAP_EN
                misalign = |req_q.addr[1:0];
`endif
            end
            default: ;
        endcase
    end

    assign access_err = (req_q.size == 2'b11) || misalign;
    assign word_idx   = req_q.addr[ADDR_W-1:2];
    assign rd_word    = mem[word_idx];
    assign rd_byte    = rd_word[{lane, 3'b000} +: 8];
    assign rd_half    = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'h0;
        if (!req_q.we && !access_err) begin
            case (req_q.size)
                SZ_BYTE: load_data = req_q.uns ? {24'h0, rd_byte}
                                               : {{24{rd_byte[7]}}, rd_byte};
                SZ_HALF: load_data = req_q.uns ? {16'h0, rd_half}
                                               : {{16{rd_half[15]}}, rd_half};
                SZ_WORD: load_data = rd_word;
                default: load_data = 32'h0;
            endcase
        end
    end

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = req_q.wdata;
        case (req_q.size)
            SZ_BYTE: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{req_q.wdata[7:0]}};
            end
            SZ_HALF: begin
                wr_be   = 4'b0011 << lane;
                wr_data = {2{req_q.wdata[15:0]}};
            end
            SZ_WORD: wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    // A reset forces state to IDLE, so a store still waiting is never written.
    assign mem_we = (state == ACCESS) && req_q.we && !access_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else if (state == ACCESS) begin
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
            resp_err   <= access_err;
        end else if ((state == RESP) && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL provide parameter ADDR_W, default 10, byte-address width; memory depth is 2**(ADDR_W-2) 32-bit words.
REQ-002 The block SHALL provide parameter WAIT_STATES, default 1, range 0-15, extra cycles inserted before each access.
REQ-003 The block SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL provide port req_valid  input  1  request present.
REQ-006 The block SHALL provide port req_ready  output  1  block accepts a request this cycle.
REQ-007 The block SHALL provide port req_we  input  1  1 = store, 0 = load.
REQ-008 The block SHALL provide port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 The block SHALL provide port req_unsigned  input  1  zero-extend loads (LBU/LHU) when 1.
REQ-010 The block SHALL provide port req_addr  input  ADDR_W  byte address.
REQ-011 The block SHALL provide port req_wdata  input  32  store data, right-aligned.
REQ-012 The block SHALL provide port resp_valid  output  1  response present.
REQ-013 The block SHALL provide port resp_ready  input  1  consumer accepts response.
REQ-014 The block SHALL provide port resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 The block SHALL provide port resp_err  output  1  request was faulted and not performed.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT, ACCESS, RESP.
REQ-017 The block SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1, capturing all req_* fields.
REQ-018 On acceptance the block SHALL go to WAIT with a down-counter loaded with WAIT_STATES, or directly to ACCESS when WAIT_STATES=0.
REQ-019 In WAIT the counter SHALL decrement each cycle; the transition to ACCESS SHALL occur on the edge where it reaches 1.
REQ-020 In ACCESS the block SHALL perform exactly one array read or byte-enabled write at word index addr[ADDR_W-1:2], then go to RESP.
REQ-021 Latency: resp_valid SHALL first be high in the cycle following edge T0+WAIT_STATES+1, where T0 is the acceptance edge.
REQ-022 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until an edge with resp_ready=1, then return to IDLE; no new request is accepted in that same cycle.
REQ-023 Stores: byte at lane addr[1:0], half at lane addr[1]; only the addressed bytes SHALL change.
REQ-024 Loads: the selected byte/half SHALL be sign-extended unless req_unsigned=1; req_unsigned SHALL be ignored for word loads.
REQ-025 req_size=11 SHALL set resp_err=1, leave memory unmodified, and return resp_rdata=0 after the normal latency.
REQ-026 Address wrap: the top word index SHALL NOT wrap into index 0; every address is in range by construction.

Reset
REQ-027 On rst_n=0, asynchronously: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1 after release.
REQ-028 Reset during WAIT or ACCESS before the write edge SHALL discard the pending store; memory array contents SHALL NOT be reset.

Configuration
REQ-029 With macro DATA_MEM_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL set resp_err=1 and SHALL NOT be performed.
REQ-030 Without DATA_MEM_MISALIGN_TRAP_EN, misaligned low address bits SHALL be forced to the natural alignment (half: addr[0]=0; word: addr[1:0]=0), the access performed, and resp_err=0.

Verification
REQ-031 SW 0xDEADBEEF at 0x010, then LW 0x010 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid first high WAIT_STATES+1 cycles after each acceptance.
REQ-032 After REQ-031: SB 0x7F at 0x012, LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LW 0x010 -> 0xDE7FBEEF.
REQ-033 SH 0x8001 at 0x020, LH 0x020 -> 0xFFFF8001; LHU 0x020 -> 0x00008001; reserved req_size=11 -> resp_err=1, rdata=0.
REQ-034 LW 0x011 -> with macro: resp_err=1, memory untouched; without: rdata equals word at 0x010.
REQ-035 Hold resp_ready=0 for 5 cycles with resp_valid=1 -> outputs stable, req_ready=0 throughout; then WAIT_STATES=0 build gives response one cycle after acceptance.
REQ-036 Assert rst_n=0 mid-WAIT of SW 0x12345678 at 0x030 -> immediate IDLE, resp_valid=0; later LW 0x030 returns the prior value.
